// File: rtl/ks_pkg.sv
// Shared types and helpers for the Kogge-Stone add/subtract pipe.
package ks_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  localparam int unsigned KS_DEF_WIDTH = 32;

  // Generate/propagate pair at the default operand width.
  typedef struct packed {
    logic [KS_DEF_WIDTH-1:0] g;
    logic [KS_DEF_WIDTH-1:0] p;
  } gp_t;

  // Number of Kogge-Stone prefix levels for a power-of-two width.
  function automatic int unsigned ks_levels(input int unsigned width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/ks_prefix_levels.sv
// Combinational Kogge-Stone prefix levels FIRST_LVL..LAST_LVL.
// Level k combines each bit with the group 2**(k-1) positions below it.
module ks_prefix_levels #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned FIRST_LVL = 1,
  parameter int unsigned LAST_LVL  = 5
) (
  input  logic [WIDTH-1:0] g_i,
  input  logic [WIDTH-1:0] p_i,
  output logic [WIDTH-1:0] g_o,
  output logic [WIDTH-1:0] p_o
);

  logic [WIDTH-1:0] g_cur;
  logic [WIDTH-1:0] p_cur;

  always_comb begin
    // NOTE: defaults first, so every path assigns g_cur/p_cur and no latch is inferred.
    g_cur = g_i;
    p_cur = p_i;
    // NOTE: blocking assignments chain each level's result into the next within one evaluation.
    for (int unsigned lvl = FIRST_LVL; lvl <= LAST_LVL; lvl++) begin
      g_cur = g_cur | (p_cur & (g_cur << (1 << (lvl - 1))));
      p_cur = p_cur & ((p_cur << (1 << (lvl - 1))) |
                       ((WIDTH'(1) << (1 << (lvl - 1))) - WIDTH'(1)));
    end
    g_o = g_cur;
    p_o = p_cur;
  end

endmodule

// File: rtl/ks_addsub_pipe.sv
// Three-stage valid/ready Kogge-Stone add/subtract unit.
// Define KSA_OVF_EN to add the registered signed-overflow output out_ovf.
module ks_addsub_pipe
  import ks_pkg::*;
#(
  parameter int unsigned WIDTH = KS_DEF_WIDTH,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
`ifdef KSA_OVF_EN
  output logic             out_ovf,
`endif
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned LVLS    = ks_levels(WIDTH);
  localparam int unsigned S2_LAST = LVLS / 2;

  typedef struct packed {
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
  } gp_w_t;

  logic             advance;
  logic             v1_q, v2_q, v3_q;

  op_e              op;
  logic [WIDTH-1:0] b_eff;
  gp_w_t            s1_d, s1_q;
  logic             s1_cin_q;
  logic [TAG_W-1:0] s1_tag_q;

  gp_w_t            s2_d, s2_q;
  logic [WIDTH-1:0] s2_pbit_q;
  logic             s2_cin_q;
  logic [TAG_W-1:0] s2_tag_q;

  gp_w_t            s3_grp;
  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] sum_d, sum_q;
  logic             cout_d, cout_q;
  logic [TAG_W-1:0] tag_q;

  // A stalled output freezes the whole pipe; bubbles are never squeezed out.
  assign advance  = !v3_q || out_ready;
  assign in_ready = advance;

  assign op = op_e'(in_op);

  always_comb begin
    b_eff  = (op == OP_SUB) ? ~in_b : in_b;
    s1_d.g = in_a & b_eff;
    s1_d.p = in_a ^ b_eff;
  end

  ks_prefix_levels #(
    .WIDTH    (WIDTH),
    .FIRST_LVL(1),
    .LAST_LVL (S2_LAST)
  ) u_lvl_lo (
    .g_i(s1_q.g),
    .p_i(s1_q.p),
    .g_o(s2_d.g),
    .p_o(s2_d.p)
  );

  ks_prefix_levels #(
    .WIDTH    (WIDTH),
    .FIRST_LVL(S2_LAST + 1),
    .LAST_LVL (LVLS)
  ) u_lvl_hi (
    .g_i(s2_q.g),
    .p_i(s2_q.p),
    .g_o(s3_grp.g),
    .p_o(s3_grp.p)
  );

  // carry[i] is the carry out of bit i with cin entering below bit 0.
  always_comb begin
    carry  = s3_grp.g | (s3_grp.p & {WIDTH{s2_cin_q}});
    sum_d  = s2_pbit_q ^ {carry[WIDTH-2:0], s2_cin_q};
    cout_d = carry[WIDTH-1];
  end

  // NOTE: non-blocking assignments so every stage samples the pre-edge value of the one before.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
    end else if (advance) begin
      v1_q <= in_valid;
      v2_q <= v1_q;
      v3_q <= v2_q;
    end
  end

  // NOTE: data registers have no reset; the valid bits alone say whether they hold anything.
  always_ff @(posedge clk) begin
    if (advance) begin
      s1_q      <= s1_d;
      s1_cin_q  <= in_cin;
      s1_tag_q  <= in_tag;
      s2_q      <= s2_d;
      s2_pbit_q <= s1_q.p;
      s2_cin_q  <= s1_cin_q;
      s2_tag_q  <= s1_tag_q;
      sum_q     <= sum_d;
      cout_q    <= cout_d;
      tag_q     <= s2_tag_q;
    end
  end

`ifdef KSA_OVF_EN
  logic ovf_d, ovf_q;

  // Signed overflow: carry into the MSB differs from carry out of it.
  assign ovf_d = carry[WIDTH-1] ^ carry[WIDTH-2];

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (advance) begin
      ovf_q <= ovf_d;
    end
  end

  assign out_ovf = ovf_q;
`endif

  assign out_valid = v3_q;
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_tag   = tag_q;

endmodule

// File: tb/tb_ks_addsub_pipe.sv
// Self-checking bench for ks_addsub_pipe: vector table, scoreboard queue and
// hand-written back-pressure, streaming and mid-flight reset sequences.
module tb_ks_addsub_pipe;

  localparam int W  = 32;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          in_op;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          in_cin;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_sum;
  logic          out_cout;
  logic [TW-1:0] out_tag;
`ifdef KSA_OVF_EN
  logic          out_ovf;
`endif

  ks_addsub_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_op    (in_op),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_cin   (in_cin),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_cout (out_cout),
`ifdef KSA_OVF_EN
    .out_ovf  (out_ovf),
`endif
    .out_tag  (out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  sum;
    logic          cout;
    logic          ovf;
    logic [TW-1:0] tag;
  } exp_t;

  typedef struct {
    logic          op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          cin;
    logic [TW-1:0] tag;
    logic [W-1:0]  sum;
    logic          cout;
    logic          ovf;
  } vec_t;

  int   n_checks = 0;
  int   n_errors = 0;
  int   n_out    = 0;
  int   run_len  = 0;
  int   max_run  = 0;
  int   cyc      = 0;
  exp_t sb_q[$];
  exp_t mon_e;
  vec_t vecs[10];

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] sum, input logic cout, input logic ovf,
                              input logic [TW-1:0] tag);
    exp_t e;
    e.sum  = sum;
    e.cout = cout;
    e.ovf  = ovf;
    e.tag  = tag;
    return e;
  endfunction

  // Reference: plain wide addition; overflow from operand/result sign bits.
  function automatic exp_t model(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic [TW-1:0] tag);
    logic [W-1:0] y;
    logic [W:0]   r;
    exp_t         e;
    y      = op ? ~b : b;
    r      = {1'b0, a} + {1'b0, y} + {{W{1'b0}}, cin};
    e.sum  = r[W-1:0];
    e.cout = r[W];
    e.ovf  = (a[W-1] == y[W-1]) && (r[W-1] != a[W-1]);
    e.tag  = tag;
    return e;
  endfunction

  // Output monitor: results are compared in the cycle they transfer.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      run_len = 0;
    end else if (out_valid && out_ready) begin
      n_out++;
      run_len++;
      if (run_len > max_run) max_run = run_len;
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_result: got sum %0h tag %0h with nothing outstanding", out_sum, out_tag);
      end else begin
        mon_e = sb_q.pop_front();
        check("out_sum", out_sum, mon_e.sum);
        check("out_cout", out_cout, mon_e.cout);
        check("out_tag", out_tag, mon_e.tag);
`ifdef KSA_OVF_EN
        check("out_ovf", out_ovf, mon_e.ovf);
`endif
      end
    end else begin
      run_len = 0;
    end
  end

  task automatic set_inputs(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic cin, input logic [TW-1:0] tag);
    in_op  = op;
    in_a   = a;
    in_b   = b;
    in_cin = cin;
    in_tag = tag;
  endtask

  // Entered and left just after a rising edge; pushes e when the handshake is seen.
  task automatic drive_txn(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic cin, input logic [TW-1:0] tag, input exp_t e);
    bit done = 1'b0;
    set_inputs(op, a, b, cin, tag);
    in_valid = 1'b1;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (in_ready) begin
        sb_q.push_back(e);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("accepted", done, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 50 && sb_q.size() != 0; c++) begin
      @(posedge clk);
      #1;
    end
    check("drain", sb_q.size(), 0);
  endtask

  // Counts rising edges from presenting a lone transaction until out_valid.
  task automatic latency_txn(input string name, input logic op, input logic [W-1:0] a,
                             input logic [W-1:0] b, input logic cin, input logic [TW-1:0] tag,
                             input exp_t e);
    int lat  = 0;
    bit seen = 1'b0;
    set_inputs(op, a, b, cin, tag);
    in_valid = 1'b1;
    @(negedge clk);
    check({name, "_in_ready"}, in_ready, 1);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
      else begin
        @(posedge clk);
        #1;
        lat++;
      end
    end
    check({name, "_latency"}, lat, 3);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int n0;
    int c0;
    exp_t bp_e[5];
    logic [W-1:0] ra, rb;
    logic rop, rcin;

    vecs[0] = '{1'b0, 32'h0000_0005, 32'h0000_0003, 1'b0, 4'h1, 32'h0000_0008, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 4'h2, 32'h0000_0000, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 32'd10,        32'd3,         1'b1, 4'h3, 32'h0000_0007, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 32'd3,         32'd10,        1'b1, 4'h4, 32'hFFFF_FFF9, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 4'h5, 32'h8000_0000, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 32'h1234_5678, 32'h1234_5678, 1'b1, 4'h6, 32'h0000_0000, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 4'h7, 32'h0000_0000, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 32'h8000_0000, 32'h0000_0001, 1'b1, 4'h8, 32'h7FFF_FFFF, 1'b1, 1'b1};
    vecs[8] = '{1'b0, 32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 4'h9, 32'h0000_0000, 1'b1, 1'b0};
    vecs[9] = '{1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0, 4'hB, 32'hFFFF_FFFF, 1'b0, 1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    set_inputs(1'b0, '0, '0, 1'b0, '0);

    // Reset behaviour.
    idle(2);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_out_valid", out_valid, 0);
    @(posedge clk);
    #1;

    // Lone ADD with latency measurement.
    latency_txn("t1", 1'b0, 32'h0000_0005, 32'h0000_0003, 1'b0, 4'hA,
                mk(32'h0000_0008, 1'b0, 1'b0, 4'hA));
    wait_drain();

    // Vector table, back-to-back.
    foreach (vecs[i])
      drive_txn(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].tag,
                mk(vecs[i].sum, vecs[i].cout, vecs[i].ovf, vecs[i].tag));
    wait_drain();

    // Back-pressure: only three fit while the output is stalled.
    n0 = n_out;
    for (int i = 0; i < 5; i++)
      bp_e[i] = model(i[0], 32'h0100_0000 * (i + 1), 32'h0000_0033 + i, 1'b1, TW'(4'hC + i));
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      set_inputs(idx[0], 32'h0100_0000 * (idx + 1), 32'h0000_0033 + idx, 1'b1, TW'(4'hC + idx));
      in_valid = 1'b1;
      @(negedge clk);
      if (in_ready) begin
        sb_q.push_back(bp_e[idx]);
        idx++;
      end
      @(posedge clk);
      #1;
    end
    check("bp_accepted", idx, 3);
    @(negedge clk);
    check("bp_in_ready_low", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    check("bp_head_sum", out_sum, bp_e[0].sum);
    check("bp_head_tag", out_tag, bp_e[0].tag);
    repeat (3) @(negedge clk);
    check("bp_hold_in_ready", in_ready, 0);
    check("bp_hold_sum", out_sum, bp_e[0].sum);
    check("bp_hold_cout", out_cout, bp_e[0].cout);
    check("bp_hold_tag", out_tag, bp_e[0].tag);
`ifdef KSA_OVF_EN
    check("bp_hold_ovf", out_ovf, bp_e[0].ovf);
`endif
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && idx < 5; c++) begin
      set_inputs(idx[0], 32'h0100_0000 * (idx + 1), 32'h0000_0033 + idx, 1'b1, TW'(4'hC + idx));
      in_valid = 1'b1;
      @(negedge clk);
      if (in_ready) begin
        sb_q.push_back(bp_e[idx]);
        idx++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("bp_all_accepted", idx, 5);
    wait_drain();
    check("bp_out_count", n_out - n0, 5);

    // Random stream with gaps.
    n0 = n_out;
    for (int i = 0; i < 20; i++) begin
      int gap;
      gap = $urandom_range(0, 3);
      if (gap >= 2) idle(gap - 1);
      rop  = 1'($urandom_range(0, 1));
      rcin = 1'($urandom_range(0, 1));
      ra   = $urandom;
      rb   = $urandom;
      drive_txn(rop, ra, rb, rcin, TW'(i), model(rop, ra, rb, rcin, TW'(i)));
    end
    wait_drain();
    check("stream_count", n_out - n0, 20);

    // Full-rate burst: one acceptance and one result per cycle.
    idle(2);
    max_run = 0;
    c0 = cyc;
    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = $urandom;
      drive_txn(1'b0, ra, rb, 1'b0, TW'(i), model(1'b0, ra, rb, 1'b0, TW'(i)));
    end
    check("burst_accept_cycles", cyc - c0, 8);
    wait_drain();
    check("burst_max_run", max_run, 8);

    // Reset with three entries in flight.
    for (int i = 0; i < 3; i++)
      drive_txn(1'b0, 32'h0000_1000 + i, 32'd1, 1'b0, TW'(i),
                model(1'b0, 32'h0000_1000 + i, 32'd1, 1'b0, TW'(i)));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_out_valid", out_valid, 0);
    @(posedge clk);
    #1;
    idle(4);
    latency_txn("rst_add", 1'b0, 32'd1, 32'd1, 1'b0, 4'h5, mk(32'd2, 1'b0, 1'b0, 4'h5));
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
